// File: rtl/footswitch_ctrl.sv
// Footswitch input path: synchronizer, debounce, short/long press classification.
// Press pulse NUM_FF+DEBOUNCE_CYC edges after the first pressed sample; the input has no backpressure.
module footswitch_ctrl #(
    parameter int NUM_FF       = 2,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 4096,
    parameter int LONG_CYC     = 1 << 20,
    parameter int PRESET_W     = 2,
    parameter bit BYPASS_INIT  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sw_i,
    output logic                pressed_o,
    output logic                press_pulse_o,
    output logic                long_pulse_o,
    output logic                bypass_o,
    output logic [PRESET_W-1:0] preset_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic              REL_LVL   = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    typedef enum logic [2:0] {IDLE, DB_PRS, PRESSED, LONG, DB_REL} state_t;

    state_t              state_q, state_d;
    logic [NUM_FF-1:0]   sync_q;
    logic [DB_W-1:0]     db_q, db_d, db_inc;
    logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;
    logic                short_q, short_d;
    logic                press_d, long_d, bypass_d;
    logic [PRESET_W-1:0] preset_d;
    logic                s;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {NUM_FF{REL_LVL}};
        end else begin
            sync_q <= {sync_q[NUM_FF-2:0], sw_i};
        end
    end

    assign s        = sync_q[NUM_FF-1] ^ REL_LVL;
    assign db_inc   = (db_q == '1) ? db_q : db_q + DB_W'(1);
    assign hold_inc = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            db_q          <= '0;
            hold_q        <= '0;
            short_q       <= 1'b0;
            press_pulse_o <= 1'b0;
            long_pulse_o  <= 1'b0;
            bypass_o      <= BYPASS_INIT;
            preset_o      <= '0;
        end else begin
            state_q       <= state_d;
            db_q          <= db_d;
            hold_q        <= hold_d;
            short_q       <= short_d;
            press_pulse_o <= press_d;
            long_pulse_o  <= long_d;
            bypass_o      <= bypass_d;
            preset_o      <= preset_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        db_d     = db_q;
        hold_d   = hold_q;
        short_d  = short_q;
        press_d  = 1'b0;
        long_d   = 1'b0;
        bypass_d = bypass_o;
        preset_d = preset_o;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DB_PRS;
                    db_d    = DB_W'(1);
                end
            end
            DB_PRS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (db_q == DB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    db_d = db_inc;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = DB_REL;
                    short_d = 1'b1;
                    db_d    = DB_W'(1);
                end else begin
                    if (hold_q == HOLD_LAST) begin
                        state_d  = LONG;
                        long_d   = 1'b1;
                        preset_d = preset_o + PRESET_W'(1);
                    end
                    hold_d = hold_inc;
                end
            end
            LONG: begin
                if (!s) begin
                    state_d = DB_REL;
                    short_d = 1'b0;
                    db_d    = DB_W'(1);
                end
            end
            DB_REL: begin
                // A release glitch resumes the hold where it left off.
                if (s) begin
                    state_d = short_q ? PRESSED : LONG;
                end else if (db_q == DB_LAST) begin
                    state_d = IDLE;
                    if (short_q) begin
                        bypass_d = ~bypass_o;
                    end
                end else begin
                    db_d = db_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pressed_o = (state_q == PRESSED) || (state_q == LONG) || (state_q == DB_REL);

endmodule
